// File: rtl/q_dot_sequencer.sv
// Signed Q16.48 dot-product sequencer: streams one component pair per cycle
// through an external shared multiplier and accumulates with saturation.
module q_dot_sequencer #(
    parameter int VEC_LEN = 3,
    parameter int IDX_W   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [64*VEC_LEN-1:0]    in_a,
    input  logic [64*VEC_LEN-1:0]    in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [63:0]       out_res,
    output logic                     out_sat,
    output logic [63:0]              mul_a,
    output logic [63:0]              mul_b,
    input  logic signed [63:0]       mul_res
);

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [IDX_W-1:0]            r_idx;
    logic [DATA_W*VEC_LEN-1:0]   r_a;
    logic [DATA_W*VEC_LEN-1:0]   r_b;
    logic signed [DATA_W-1:0]    r_acc;
    logic                        r_sat;
    logic [DATA_W-1:0]           w_opa;
    logic [DATA_W-1:0]           w_opb;
    logic                        w_last;
    logic                        w_accept;

    function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return s[DATA_W] != s[DATA_W-1];
    endfunction

    // Clamp toward the sign of the 65-bit true sum on overflow.
    function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
    endfunction

    assign w_last   = (r_idx == IDX_W'(VEC_LEN-1));
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_opa = '0;
        w_opb = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_opa = r_a[DATA_W*i +: DATA_W];
                w_opb = r_b[DATA_W*i +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MUL;
            S_MUL:   if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        mul_a     = '0;
        mul_b     = '0;
        if (r_state == S_MUL) begin
            mul_a = w_opa;
            mul_b = w_opb;
        end
    end

    // Operands are snapshotted at accept so the upstream stage may move on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_sat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_acc <= '0;
                        r_sat <= 1'b0;
                        r_idx <= '0;
                    end
                end
                S_MUL: begin
                    r_acc <= sat_add(r_acc, mul_res);
                    r_sat <= r_sat | add_ovf(r_acc, mul_res);
                    if (!w_last)
                        r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_res = r_acc;
    assign out_sat = r_sat;

endmodule

// File: tb/tb_q_dot_sequencer.sv
// Scoreboard bench for q_dot_sequencer with a behavioural Q16.48 multiplier.
module tb_q_dot_sequencer;

    localparam int VL = 3;

    localparam logic [63:0] F0     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] F1     = 64'h0001_0000_0000_0000;
    localparam logic [63:0] F2     = 64'h0002_0000_0000_0000;
    localparam logic [63:0] F3     = 64'h0003_0000_0000_0000;
    localparam logic [63:0] F4     = 64'h0004_0000_0000_0000;
    localparam logic [63:0] F5     = 64'h0005_0000_0000_0000;
    localparam logic [63:0] F6     = 64'h0006_0000_0000_0000;
    localparam logic [63:0] F7     = 64'h0007_0000_0000_0000;
    localparam logic [63:0] FM1P5  = 64'hFFFE_8000_0000_0000;
    localparam logic [63:0] FP5    = 64'h0000_8000_0000_0000;
    localparam logic [63:0] FP25   = 64'h0000_4000_0000_0000;
    localparam logic [63:0] F181   = 64'h00B5_0000_0000_0000;
    localparam logic [63:0] FM181  = 64'hFF4B_0000_0000_0000;
    localparam logic [63:0] R32    = 64'h0020_0000_0000_0000;
    localparam logic [63:0] RM2875 = 64'hFFFD_2000_0000_0000;
    localparam logic [63:0] RMAX   = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] RMIN   = 64'h8000_0000_0000_0000;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [64*VL-1:0]       in_a = '0;
    logic [64*VL-1:0]       in_b = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic signed [63:0]     out_res;
    logic                   out_sat;
    logic [63:0]            mul_a;
    logic [63:0]            mul_b;
    logic signed [63:0]     mul_res;
    logic signed [127:0]    prod;

    q_dot_sequencer #(.VEC_LEN(VL), .IDX_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_sat(out_sat),
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res)
    );

    always #5 clk = ~clk;

    always_comb prod = $signed(mul_a) * $signed(mul_b);
    assign mul_res = prod[111:48];

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           acc_cyc = 0;
    logic [64:0]  sb[$];
    logic [64:0]  mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got res %h sat %0d with nothing expected", out_res, out_sat);
            end else begin
                mon_exp = sb.pop_front();
                chk("out_res", out_res, mon_exp[63:0]);
                chk("out_sat", 64'(out_sat), 64'(mon_exp[64]));
            end
        end
    end

    task automatic send(input logic [64*VL-1:0] a, input logic [64*VL-1:0] b,
                        input logic [63:0] er, input logic es, input bit keep);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %0d, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            sb.push_back({es, er});
            @(posedge clk); #1;
            acc_cyc = cyc;
            if (!keep) in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int e_cyc;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res", out_res, F0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_mul_a", mul_a, F0);
        chk("rst_mul_b", mul_b, F0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic with operand sequence and latency
        send({F3, F2, F1}, {F6, F5, F4}, R32, 1'b0, 1'b0);
        chk("basic_mul_a0", mul_a, F1);
        chk("basic_mul_b0", mul_b, F4);
        chk("basic_valid_early0", 64'(out_valid), 64'd0);
        chk("basic_in_ready_mul", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("basic_mul_a1", mul_a, F2);
        chk("basic_mul_b1", mul_b, F5);
        @(posedge clk); #1;
        chk("basic_mul_a2", mul_a, F3);
        chk("basic_mul_b2", mul_b, F6);
        chk("basic_valid_early2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("basic_valid_rise", 64'(out_valid), 64'd1);
        chk("basic_mul_a_done", mul_a, F0);
        chk("basic_in_ready_done", 64'(in_ready), 64'd0);
        drain();

        // Signed / fractional
        send({F0, FP5, FM1P5}, {F7, FP25, F2}, RM2875, 1'b0, 1'b0);
        drain();

        // Positive and negative saturation
        send({F181, F181, F181}, {F181, F181, F181}, RMAX, 1'b1, 1'b0);
        drain();
        send({FM181, FM181, FM181}, {F181, F181, F181}, RMIN, 1'b1, 1'b0);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send({F181, F181, F181}, {F181, F181, F181}, RMAX, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_res", out_res, RMAX);
            chk("bp_out_sat", 64'(out_sat), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        e_cyc = cyc;
        out_ready = 1'b1;
        send({F3, F2, F1}, {F6, F5, F4}, R32, 1'b0, 1'b0);
        chk("bp_accept_gap", 64'(acc_cyc - e_cyc), 64'd2);
        drain();

        // Reset in the second MUL cycle
        send({F3, F2, F1}, {F6, F5, F4}, R32, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_mul_a", mul_a, F0);
        chk("midrst_mul_b", mul_b, F0);
        chk("midrst_out_res", out_res, F0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send({F3, F2, F1}, {F6, F5, F4}, R32, 1'b0, 1'b0);
        drain();

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        send({F3, F2, F1}, {F6, F5, F4}, R32, 1'b0, 1'b1);
        prev = acc_cyc;
        send({F0, FP5, FM1P5}, {F7, FP25, F2}, RM2875, 1'b0, 1'b1);
        chk("b2b_gap1", 64'(acc_cyc - prev), 64'(VL + 2));
        prev = acc_cyc;
        send({F181, F181, F181}, {F181, F181, F181}, RMAX, 1'b1, 1'b1);
        chk("b2b_gap2", 64'(acc_cyc - prev), 64'(VL + 2));
        prev = acc_cyc;
        send({F3, F2, F1}, {F6, F5, F4}, R32, 1'b0, 1'b0);
        chk("b2b_gap3", 64'(acc_cyc - prev), 64'(VL + 2));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
